// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_pkg
//  Description : Shared types and helpers for the wide-add sequencer: FSM
//                state encoding, adder slice width, index-width function and
//                word-slice extraction helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package wide_add_pkg;

  // Width of one adder slice; tied to the adder_16bit instance.
  localparam int WORD_WIDTH = 16;

  // Largest supported operand, in words; the slice helper works on a vector
  // padded to this size so one function serves every NUM_WORDS.
  localparam int MAX_WORDS  = 16;
  localparam int MAX_WIDTH  = WORD_WIDTH * MAX_WORDS;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index NUM_WORDS words (at least one bit).
  function automatic int idx_bits(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  // Extract word number idx from a padded operand vector.
  function automatic logic [WORD_WIDTH-1:0] word_slice(
    input logic [MAX_WIDTH-1:0] vec,
    input int                   idx
  );
    return vec[idx*WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage : wide_add_pkg
`default_nettype wire

// File: rtl/adder_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_16bit
//  Description : 16-bit ripple-carry adder. Purely combinational; the carry
//                is propagated bit by bit from cin to cout.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Ripple the carry through each full-adder bit position in order.
  always_comb begin
    logic c;
    sum  = '0;
    cout = 1'b0;
    c    = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule : adder_16bit
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer
//  Description : Adds two NUM_WORDS x 16-bit operands by stepping a single
//                shared 16-bit ripple adder over the words, least significant
//                first, chaining each word's carry-out into the next word.
//                Operands arrive and the result leaves on valid/ready
//                handshakes.
//  Options     : WIDE_ADD_SUBTRACT_EN - adds the op_sub input; when set the
//                b operand is inverted and word-0 carry forced to 1, giving
//                op_a - op_b with overflow meaning "no borrow".
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [NUM_WORDS*16-1:0] op_a,
  input  logic [NUM_WORDS*16-1:0] op_b,
  input  logic                    carry_in,
`ifdef WIDE_ADD_SUBTRACT_EN
  input  logic                    op_sub,
`endif
  output logic                    busy,
  output logic [NUM_WORDS*16-1:0] result,
  output logic                    overflow,
  output logic                    done_valid,
  input  logic                    done_ready
);

  import wide_add_pkg::*;

  localparam int                TOTAL_WIDTH = NUM_WORDS * WORD_WIDTH;
  localparam int                IDX_W       = idx_bits(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_WORDS - 1);

  // Sequencer state and datapath registers.
  state_t                  r_state;
  logic [TOTAL_WIDTH-1:0]  r_a;
  logic [TOTAL_WIDTH-1:0]  r_b;
  logic                    r_carry;
  logic [IDX_W-1:0]        r_idx;
  logic [TOTAL_WIDTH-1:0]  r_result;
  logic                    r_overflow;
  logic                    r_done_valid;
  logic                    r_busy;
  logic                    r_start_ready;
  logic                    r_sub;

  // Adder hookup.
  logic [MAX_WIDTH-1:0]    w_a_ext;
  logic [MAX_WIDTH-1:0]    w_b_ext;
  logic [WORD_WIDTH-1:0]   w_a_word;
  logic [WORD_WIDTH-1:0]   w_b_raw;
  logic [WORD_WIDTH-1:0]   w_b_word;
  logic [WORD_WIDTH-1:0]   w_sum;
  logic                    w_cout;
  logic                    w_first_carry;
  logic                    w_sub_req;

  // Pad the latched operands to the helper's fixed width so any NUM_WORDS
  // in the legal range can share the same slice function.
  always_comb begin
    w_a_ext                  = '0;
    w_b_ext                  = '0;
    w_a_ext[TOTAL_WIDTH-1:0] = r_a;
    w_b_ext[TOTAL_WIDTH-1:0] = r_b;
  end

  assign w_a_word = word_slice(w_a_ext, int'(r_idx));
  assign w_b_raw  = word_slice(w_b_ext, int'(r_idx));

`ifdef WIDE_ADD_SUBTRACT_EN
  // Subtraction is a + ~b + 1: invert every b word and seed the chain with 1.
  assign w_sub_req     = op_sub;
  assign w_b_word      = r_sub ? ~w_b_raw : w_b_raw;
  assign w_first_carry = op_sub ? 1'b1 : carry_in;
`else
  assign w_sub_req     = 1'b0;
  assign w_b_word      = w_b_raw;
  assign w_first_carry = carry_in;
`endif

  // The only adder in the design; reused once per word.
  adder_16bit u_adder (
    .a    (w_a_word),
    .b    (w_b_word),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Sequencer FSM: accept operands, step one word per cycle, hold the result
  // until the consumer takes it. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_carry       <= 1'b0;
      r_idx         <= '0;
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_done_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
      r_sub         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid && r_start_ready) begin
            // The carry register doubles as the word-0 carry-in.
            r_a           <= op_a;
            r_b           <= op_b;
            r_carry       <= w_first_carry;
            r_sub         <= w_sub_req;
            r_result      <= '0;
            r_overflow    <= 1'b0;
            r_idx         <= '0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ADD;
          end
        end

        ADD: begin
          r_result[int'(r_idx)*WORD_WIDTH +: WORD_WIDTH] <= w_sum;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            // Last word: its carry-out is the operation's overflow. The index
            // is left alone so it never wraps within a transaction.
            r_overflow   <= w_cout;
            r_done_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        DONE: begin
          if (done_ready) begin
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end

        default: begin
          r_state       <= IDLE;
          r_done_valid  <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign result      = r_result;
  assign overflow    = r_overflow;
  assign done_valid  = r_done_valid;

endmodule : wide_add_sequencer
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_sequencer
//  Description : Self-checking bench for wide_add_sequencer (NUM_WORDS=4).
//                Expected sums come from a plain-arithmetic reference model
//                and are queued at issue time; a monitor compares them with
//                whatever the DUT presents on the done handshake.
//  Options     : WIDE_ADD_SUBTRACT_EN - also exercises subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = NW * 16;

  logic         clk         = 1'b0;
  logic         rst         = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a        = '0;
  logic [W-1:0] op_b        = '0;
  logic         carry_in    = 1'b0;
`ifdef WIDE_ADD_SUBTRACT_EN
  logic         op_sub      = 1'b0;
`endif
  logic         busy;
  logic [W-1:0] result;
  logic         overflow;
  logic         done_valid;
  logic         done_ready  = 1'b0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .carry_in    (carry_in),
`ifdef WIDE_ADD_SUBTRACT_EN
    .op_sub      (op_sub),
`endif
    .busy        (busy),
    .result      (result),
    .overflow    (overflow),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   rdy_mode = 0;   // 0 random, 1 hold low, 2 always high
  bit   seen_rise = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: the full-width sum, or difference with "no borrow" flag.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int acc);
    exp_t         e;
    logic [W:0]   full;
    if (sub) begin
      e.res = a - b;
      e.ovf = (a >= b);
    end else begin
      full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.res = full[W-1:0];
      e.ovf = full[W];
    end
    e.acc = acc;
    return e;
  endfunction

  // Monitor: drives done_ready, checks every cycle the result is presented.
  always @(negedge clk) begin
    if (!rst) begin
      case (rdy_mode)
        0:       done_ready = 1'($urandom_range(0, 1));
        1:       done_ready = 1'b0;
        default: done_ready = 1'b1;
      endcase
      if (done_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual result=%h required no output", result);
        end else begin
          if (!seen_rise) begin
            chk("latency", W'(cycle), W'(sb[0].acc + NW));
            seen_rise = 1'b1;
          end
          chk("result",         result,      sb[0].res);
          chk("overflow",       overflow,    W'(sb[0].ovf));
          chk("start_ready_dn", start_ready, '0);
          chk("busy_dn",        busy,        W'(1));
          if (done_ready) begin
            void'(sb.pop_front());
            seen_rise = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int guard = 0;
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    carry_in = cin;
`ifdef WIDE_ADD_SUBTRACT_EN
    op_sub   = sub;
`endif
    start_valid = 1'b1;
    while (!start_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!start_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual start_ready=%b required 1", start_ready);
      start_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, cin, sub, cycle + 1));
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; they must have no effect.
    start_valid = 1'b0;
    op_a        = {$urandom, $urandom};
    op_b        = {$urandom, $urandom};
    carry_in    = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_pattern();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = {$urandom, $urandom};
      1:       v = '1;
      2:       v = {16'hFFFF, 16'(($urandom)), 16'hFFFF, 16'(($urandom))};
      default: v = W'($urandom_range(0, 15));
    endcase
    return v;
  endfunction

  initial begin
    logic [W-1:0] ones;
    int           guard;
    ones = '1;

    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result",      result,      '0);
    chk("rst_overflow",    overflow,    '0);
    chk("rst_done_valid",  done_valid,  '0);
    chk("rst_busy",        busy,        '0);
    chk("rst_start_ready", start_ready, W'(1));
    rst = 1'b0;

    // Directed: zeros and carry-ripple corners.
    rdy_mode = 2;
    issue('0, '0, 1'b0, 1'b0);
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    issue(ones, '0, 1'b1, 1'b0);
    drain();

    // Randomized traffic with random consumer backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 25; i++)
      issue(rand_pattern(), rand_pattern(), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Backpressure: hold the result, poke start_valid, then release.
    rdy_mode = 1;
    issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    guard = 0;
    while (!done_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_done_valid", done_valid, W'(1));
    repeat (2) @(negedge clk);
    start_valid = 1'b1;
    op_a        = 64'h1234;
    op_b        = 64'h1;
    @(negedge clk);
    chk("bp_start_ready", start_ready, '0);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rdy_mode = 2;
    drain();
    @(posedge clk);
    #1;
    chk("bp_idle_ready", start_ready, W'(1));
    chk("bp_idle_dv",    done_valid,  '0);
    repeat (3) @(negedge clk);
    chk("bp_no_accept",  busy,        '0);

    // Reset in the middle of an operation (index at 2).
    issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    seen_rise = 1'b0;
    @(negedge clk);
    chk("mid_rst_result",      result,      '0);
    chk("mid_rst_overflow",    overflow,    '0);
    chk("mid_rst_done_valid",  done_valid,  '0);
    chk("mid_rst_busy",        busy,        '0);
    chk("mid_rst_start_ready", start_ready, W'(1));
    rst = 1'b0;
    issue(64'd3, 64'd4, 1'b0, 1'b0);
    drain();

`ifdef WIDE_ADD_SUBTRACT_EN
    issue(64'd5, 64'd7, 1'b0, 1'b1);
    issue(64'd7, 64'd5, 1'b1, 1'b1);
    rdy_mode = 0;
    for (int i = 0; i < 10; i++)
      issue(rand_pattern(), rand_pattern(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wide_add_sequencer
`default_nettype wire

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that sequences one shared 16-bit ripple adder (adder_16bit) to add two NUM_WORDS×16-bit operands, least significant word first.
- Chains each word's carry-out into the next word's carry-in.
- Handshakes operands in and the result out with valid/ready.
- Sits between a requesting datapath and the single adder instance; there is no second adder.

Parameters:
- NUM_WORDS, 4, number of 16-bit words per operand (operand width = NUM_WORDS*16); legal range 2..16.
- WORD_WIDTH, 16, adder slice width; fixed to the adder_16bit width and not overridable in practice.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  requester presents operands.
- start_ready  output  1  sequencer can accept operands (high only in IDLE).
- op_a  input  NUM_WORDS*16  operand A.
- op_b  input  NUM_WORDS*16  operand B.
- carry_in  input  1  carry into word 0.
- busy  output  1  high in ADD and DONE states.
- result  output  NUM_WORDS*16  registered sum.
- overflow  output  1  carry-out of the most significant word.
- done_valid  output  1  result/overflow valid.
- done_ready  input  1  consumer accepts result.

Behaviour:
- Reset (synchronous, rst=1 at rising clk): state=IDLE; result=0; overflow=0; done_valid=0; busy=0; start_ready=1; word index=0; internal carry=0.
- Reset has priority over every other event, including mid-operation; no partial result is retained.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: latch op_a, op_b and carry_in; clear result and overflow to 0; set idx=0; go to ADD.
- ADD:
  - Adder inputs are a_reg word[idx], b_reg word[idx], and carry_reg (carry_in for idx 0).
  - Each cycle: result word[idx] <= adder sum; carry_reg <= adder overflow; idx <= idx+1.
  - When idx==NUM_WORDS-1: overflow <= adder overflow; done_valid <= 1; go to DONE.
- DONE:
  - done_valid=1; result and overflow are held stable.
  - On done_ready: done_valid <= 0; go to IDLE.
- Latency: operands accepted at edge k; done_valid is high after edge k+NUM_WORDS.
  - Minimum issue interval is NUM_WORDS+2 cycles: accept, NUM_WORDS adds, handshake out, then back in IDLE.
- start_valid outside IDLE is ignored. Operands may change after acceptance without effect.
- done_ready outside DONE is ignored.
- Index counter width: clog2(NUM_WORDS). It never wraps during a transaction; it resets to 0 on acceptance.
- Arithmetic: result = (op_a + op_b + carry_in) mod 2^(16*NUM_WORDS); overflow = bit 16*NUM_WORDS of the full sum.
- Mid-operation result words hold partial sums and are defined only when done_valid=1.

Optional Feature:
- Macro: WIDE_ADD_SUBTRACT_EN.
- When defined:
  - Adds input op_sub (1 bit), latched with the operands.
  - When op_sub=1: every b word is inverted before the adder, and the word-0 carry is forced to 1 (carry_in ignored), so result = op_a - op_b.
  - overflow then means "no borrow" (1 when op_a >= op_b unsigned).
- When undefined: no op_sub port; addition only.

Decomposition:
- Package wide_add_pkg holds:
  - state enum (IDLE, ADD, DONE);
  - localparams WORD_WIDTH=16 and the IDX_BITS function/constant;
  - the word-slice helper function.
- One sub-module: adder_16bit, instantiated once. The sequencer contains only the FSM, operand/result registers and carry register.

Test Plan (NUM_WORDS=4):
- Reset: assert rst 2 cycles → result=0, overflow=0, done_valid=0, busy=0, start_ready=1.
- Zeros: a=0, b=0, cin=0 → result=64'h0, overflow=0; done_valid rises exactly 4 cycles after the accept edge.
- Carry ripple: a=64'h0000_0000_0000_FFFF, b=64'h1, cin=0 → result=64'h0000_0000_0001_0000, overflow=0. Also a=all-ones, b=0, cin=1 → result=0, overflow=1.
- Backpressure: hold done_ready=0 for 5 cycles after done → done_valid, result and overflow stable. start_valid pulsed meanwhile → start_ready=0 and the request is not accepted. done_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst while idx=2 → next cycle state=IDLE, all outputs at reset values. A following a=3, b=4 → result=7.
- With WIDE_ADD_SUBTRACT_EN: a=5, b=7, op_sub=1 → result=64'hFFFF_FFFF_FFFF_FFFE, overflow=0. a=7, b=5 → result=2, overflow=1.
